load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of valid data-memory words.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  unit can accept a request.
REQ-008 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_base  in  ADDR_W  base register value.
REQ-010 SHALL have port req_offset  in  ADDR_W  two's-complement offset.
REQ-011 SHALL have port req_wdata  in  DATA_W  store data.
REQ-012 SHALL have port req_rd  in  3  destination register tag.
REQ-013 SHALL have port resp_valid  out  1  response present.
REQ-014 SHALL have port resp_ready  in  1  consumer accepts response.
REQ-015 SHALL have port resp_rdata  out  DATA_W  load data (0 for stores and errors).
REQ-016 SHALL have port resp_rd  out  3  tag echoed from request.
REQ-017 SHALL have port resp_err  out  1  address out of range.
REQ-018 SHALL have ports mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_read  out  1, mem_write  out  1  drive the data memory.
REQ-019 SHALL have port mem_rdata  in  DATA_W  data memory read data, valid the cycle after mem_read is sampled.
REQ-020 SHALL have ports cnt_loads, cnt_stores, cnt_errs  out  16 each  saturating event counters.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-022 SHALL assert req_ready only in IDLE; a handshake is req_valid && req_ready at posedge clk.
REQ-023 SHALL, on handshake, latch write, wdata, rd, and effective address EA = (req_base + req_offset) mod 2^ADDR_W, with overflow carry discarded.
REQ-024 SHALL, if EA >= MEM_DEPTH, go IDLE->RESP with resp_err=1 and resp_rdata=0, and never assert mem_read/mem_write for that request.
REQ-025 SHALL otherwise go IDLE->ISSUE; in ISSUE drive mem_addr=EA, mem_wdata=latched wdata, and exactly one of mem_read (load) or mem_write (store) high for exactly one cycle.
REQ-026 SHALL hold mem_read and mem_write low in every state other than ISSUE.
REQ-027 SHALL go ISSUE->CAPTURE; in CAPTURE latch mem_rdata into resp_rdata for loads, 0 for stores; then go CAPTURE->RESP.
REQ-028 SHALL assert resp_valid only in RESP, holding resp_rdata, resp_rd and resp_err stable until resp_ready is high at a posedge, then go RESP->IDLE.
REQ-029 SHALL have latency: handshake at edge N -> resp_valid high after edge N+3 (in-range), after edge N+1 (error); throughput of one request per 4 cycles minimum.
REQ-030 SHALL not accept a new request in the cycle resp is consumed (req_ready goes high only after return to IDLE).
REQ-031 SHALL increment cnt_loads/cnt_stores on entry to CAPTURE and cnt_errs on error detection, each saturating at 0xFFFF.
REQ-032 SHALL treat EA = MEM_DEPTH-1 as valid and EA = MEM_DEPTH as error.

Reset
REQ-033 SHALL, on rst_n low, immediately (asynchronously) enter IDLE and drive req_ready=1 (once rst_n high), resp_valid=0, resp_rdata=0, resp_rd=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0, and all counters to 0.
REQ-034 SHALL, on reset mid-operation, drop the in-flight request with no response and no further memory strobe.

Verification
REQ-035 SHALL pass: store base=0x0010, offset=0x0004, wdata=0xBEEF, rd=2 -> one ISSUE cycle with mem_write=1, mem_addr=0x0014; resp after 3 edges, rdata=0, rd=2, err=0; cnt_stores=1.
REQ-036 SHALL pass: load base=0x0020, offset=0xFFFC, memory word 0x001C=0x1234 -> mem_read=1 with mem_addr=0x001C; resp_rdata=0x1234, err=0; cnt_loads=1.
REQ-037 SHALL pass: load base=0x03FF, offset=0x0001 -> no mem strobe, resp after 1 edge with err=1, rdata=0; cnt_errs=1; base=0x03FF, offset=0 -> valid access.
REQ-038 SHALL pass: load with resp_ready held low for 5 cycles -> resp_valid and payload stable, req_ready=0 throughout; released one cycle after resp_ready=1.
REQ-039 SHALL pass: rst_n asserted during ISSUE of a store -> mem_write drops immediately, no response, outputs at reset values, cnt_stores=0.
REQ-040 SHALL pass: 0x10000 forced error events -> cnt_errs saturates at 0xFFFF.

Source files
------------

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: forms base+offset, range-checks it against
// MEM_DEPTH, performs at most one memory access and returns a tagged response.
module load_store_unit #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [2:0]        resp_rd,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  cnt_loads,
  output logic [CNT_W-1:0]  cnt_stores,
  output logic [CNT_W-1:0]  cnt_errs,
  output logic [1:0]        dbgState
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both high;
  // the sender keeps valid and its payload stable until that posedge.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsuState_e;

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  lsuState_e         state;
  lsuState_e         stateNext;
  logic [ADDR_W-1:0] effAddr;
  logic [ADDR_W-1:0] eaQ;
  logic              addrErr;
  logic              reqFire;
  logic              wrQ;
  logic              errQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] rdataQ;
  logic [2:0]        rdQ;
  logic [CNT_W-1:0]  loadCnt;
  logic [CNT_W-1:0]  storeCnt;
  logic [CNT_W-1:0]  errCnt;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Same-width add drops the carry, so the address wraps modulo 2^ADDR_W.
  assign effAddr = req_base + req_offset;
  assign addrErr = ({1'b0, effAddr} >= DEPTH_LIM);
  assign reqFire = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (req_valid) stateNext = addrErr ? RESP : ISSUE;
      ISSUE:   stateNext = CAPTURE;
      CAPTURE: stateNext = RESP;
      RESP:    if (resp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Memory strobes are decoded from state so a reset removes them without waiting for a clock.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state == ISSUE) begin
      mem_read  = !wrQ;
      mem_write = wrQ;
      mem_addr  = eaQ;
      mem_wdata = wdataQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrQ    <= 1'b0;
      errQ   <= 1'b0;
      wdataQ <= '0;
      rdataQ <= '0;
      rdQ    <= '0;
      eaQ    <= '0;
    end else begin
      if (reqFire) begin
        wrQ    <= req_write;
        wdataQ <= req_wdata;
        rdQ    <= req_rd;
        eaQ    <= effAddr;
        errQ   <= addrErr;
        rdataQ <= '0;
      end
      if (state == CAPTURE) rdataQ <= wrQ ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadCnt  <= '0;
      storeCnt <= '0;
      errCnt   <= '0;
    end else begin
      if (state == ISSUE) begin
        if (wrQ) storeCnt <= satInc(storeCnt);
        else     loadCnt  <= satInc(loadCnt);
      end
      if (reqFire && addrErr) errCnt <= satInc(errCnt);
    end
  end

  assign resp_rdata = rdataQ;
  assign resp_rd    = rdQ;
  assign resp_err   = errQ;
  assign cnt_loads  = loadCnt;
  assign cnt_stores = storeCnt;
  assign cnt_errs   = errCnt;
  assign dbgState   = state;

endmodule
